// File: rtl/scan_decoder_pkg.sv
// Shared types and helpers for the scan decoder and its one-hot sub-decoder.
package scan_decoder_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Widest select the helper supports; callers narrow the result to their own N.
    localparam int unsigned MAX_SEL_W = 8;
    localparam int unsigned MAX_N     = 2 ** MAX_SEL_W;

    typedef enum logic {
        ST_DIRECT = MODE_DIRECT,
        ST_SCAN   = MODE_SCAN
    } state_t;

    // Active-high one-hot of sel.
    function automatic logic [MAX_N-1:0] onehot(input logic [MAX_SEL_W-1:0] sel);
        logic [MAX_N-1:0] v;
        v      = '0;
        v[sel] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/scan_decoder_if.sv
// Enable, select and scan-control inputs plus decoded outputs of the scan decoder.
interface scan_decoder_if #(
    parameter int unsigned SEL_W   = 3,
    parameter int unsigned DWELL_W = 16
);
    localparam int unsigned N = 2 ** SEL_W;

    logic               g1;
    logic               g2a_n;
    logic               g2b_n;
    logic               mode;
    logic               addr_valid;
    logic [SEL_W-1:0]   addr;
    logic [DWELL_W-1:0] dwell;
    logic [N-1:0]       y;
    logic [SEL_W-1:0]   cur_sel;
    logic               wrap;

    modport master (
        output g1, g2a_n, g2b_n, mode, addr_valid, addr, dwell,
        input  y, cur_sel, wrap
    );

    modport slave (
        input  g1, g2a_n, g2b_n, mode, addr_valid, addr, dwell,
        output y, cur_sel, wrap
    );
endinterface

// File: rtl/scan_decoder_onehot_dec.sv
// Combinational SEL_W -> 2**SEL_W decoder with enable and selectable output polarity.
module onehot_dec
    import scan_decoder_pkg::*;
#(
    parameter int unsigned SEL_W      = 3,
    parameter int unsigned ACTIVE_LOW = 1
) (
    input  logic [SEL_W-1:0]    i_sel,
    input  logic                i_en,
    output logic [2**SEL_W-1:0] o_y_c
);
    localparam int unsigned N = 2 ** SEL_W;

    logic [N-1:0] w_hot;

    // Decode, gate by enable, then apply output polarity.
    always_comb begin
        w_hot = '0;
        if (i_en) begin
            w_hot = N'(onehot(MAX_SEL_W'(i_sel)));
        end
        o_y_c = (ACTIVE_LOW != 0) ? ~w_hot : w_hot;
    end
endmodule

// File: rtl/scan_decoder.sv
// Registered one-hot decoder with 74x138-style enables and a dwell-timed scan mode.
module scan_decoder
    import scan_decoder_pkg::*;
#(
    parameter int unsigned SEL_W      = 3,
    parameter int unsigned DWELL_W    = 16,
    parameter int unsigned ACTIVE_LOW = 1
) (
    input  logic          clk,
    input  logic          rst,
    scan_decoder_if.slave bus
);
    localparam int unsigned N = 2 ** SEL_W;
    localparam logic [N-1:0] Y_IDLE = {N{ACTIVE_LOW != 0}};

    state_t             r_state;
    state_t             w_state_nxt;
    logic [SEL_W-1:0]   r_cur_sel;
    logic [SEL_W-1:0]   w_cur_sel_nxt;
    logic [DWELL_W-1:0] r_dwell_cnt;
    logic [DWELL_W-1:0] w_dwell_cnt_nxt;
    logic               r_wrap;
    logic               w_wrap_nxt;
    logic [N-1:0]       r_y;
    logic [N-1:0]       w_y_nxt;
    logic               w_en;

    assign w_en = bus.g1 & ~bus.g2a_n & ~bus.g2b_n;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_DIRECT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state simply follows the mode input every edge.
    always_comb begin
        w_state_nxt = ST_DIRECT;
        if (bus.mode == MODE_SCAN) begin
            w_state_nxt = ST_SCAN;
        end
    end

    // Next select, dwell counter and wrap; a state change only clears the counter.
    always_comb begin
        w_cur_sel_nxt   = r_cur_sel;
        w_dwell_cnt_nxt = r_dwell_cnt;
        w_wrap_nxt      = 1'b0;
        if (w_state_nxt != r_state) begin
            w_dwell_cnt_nxt = '0;
        end else begin
            case (r_state)
                ST_DIRECT: begin
                    w_dwell_cnt_nxt = '0;
                    if (bus.addr_valid && w_en) begin
                        w_cur_sel_nxt = bus.addr;
                    end
                end
                ST_SCAN: begin
                    if (w_en) begin
                        if (bus.addr_valid) begin
                            w_cur_sel_nxt   = bus.addr;
                            w_dwell_cnt_nxt = '0;
                        end else if (r_dwell_cnt >= bus.dwell) begin
                            w_cur_sel_nxt   = SEL_W'(r_cur_sel + 1'b1);
                            w_dwell_cnt_nxt = '0;
                            w_wrap_nxt      = (r_cur_sel == SEL_W'(N - 1));
                        end else begin
                            w_dwell_cnt_nxt = DWELL_W'(r_dwell_cnt + 1'b1);
                        end
                    end
                end
                default: begin
                    w_dwell_cnt_nxt = '0;
                end
            endcase
        end
    end

    // Decode of the upcoming select feeds the y register directly.
    onehot_dec #(
        .SEL_W      (SEL_W),
        .ACTIVE_LOW (ACTIVE_LOW)
    ) u_onehot_dec (
        .i_sel (w_cur_sel_nxt),
        .i_en  (w_en),
        .o_y_c (w_y_nxt)
    );

    // Output and datapath registers; y is rewritten every cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_y         <= Y_IDLE;
            r_cur_sel   <= '0;
            r_dwell_cnt <= '0;
            r_wrap      <= 1'b0;
        end else begin
            r_y         <= w_y_nxt;
            r_cur_sel   <= w_cur_sel_nxt;
            r_dwell_cnt <= w_dwell_cnt_nxt;
            r_wrap      <= w_wrap_nxt;
        end
    end

    assign bus.y       = r_y;
    assign bus.cur_sel = r_cur_sel;
    assign bus.wrap    = r_wrap;
endmodule
